garage_door_plant: RTL and testbench
====================================

// Module: garage_door_plant
// PURPOSE
//  Cycle-accurate, synthesizable model of the garage door mechanism: the motor and limit-switch
//  end of the door-control interface. Consumes motor commands UP_M/DN_M, tracks door position
//  and drives limit switches UP_Max/DN_Max back to the controller. Used as the closed-loop plant
//  in system benches and FPGA demos; also flags illegal commands and obstruction stops.
// PARAMETERS
//  TRAVEL_STEPS  8   position steps from fully closed (0) to fully open (TRAVEL_STEPS), >=2
//  STEP_DIV      4   clock cycles per position step while moving, >=1
//  INIT_POS      0   position loaded on reset, 0..TRAVEL_STEPS
//  POS_W         $clog2(TRAVEL_STEPS+1)  derived width of Position; not overridden
// PORTS
//  CLK          in   1      clock, rising edge
//  RST          in   1      reset, synchronous, active-low
//  UP_M         in   1      motor-up command
//  DN_M         in   1      motor-down command
//  Obstruct     in   1      beam-break sensor, 1 = object under door
//  Fault_Clr    in   1      clears FAULT state
//  UP_Max       out  1      1 when Position == TRAVEL_STEPS
//  DN_Max       out  1      1 when Position == 0
//  Position     out  POS_W  current door position
//  Moving       out  1      1 in RISING or FALLING
//  Fault        out  1      1 in FAULT
//  Obstr_Evt    out  1      one-cycle pulse: descent aborted by Obstruct
// BEHAVIOUR
//  Reset (RST==0 at edge): state=STOPPED, Position=INIT_POS, prescaler=0, Obstr_Evt=0; hence
//   Moving=0, Fault=0, UP_Max/DN_Max decoded from INIT_POS. Reset overrides everything, any state.
//  UP_Max/DN_Max/Moving/Fault: pure decode of registered state/Position, no added latency.
//  States: STOPPED, RISING, FALLING, FAULT. Priority at each edge: RST, then UP_M&DN_M -> FAULT
//   (from any state, no step that edge), then per-state rules:
//  STOPPED: UP_M & Position<TRAVEL_STEPS -> RISING; DN_M & Position>0 & !Obstruct -> FALLING;
//   command toward an already-reached limit is ignored (stay STOPPED).
//  RISING: UP_M==0 -> STOPPED, no step. Else prescaler++; at prescaler==STEP_DIV-1: Position++,
//   prescaler=0; if new Position==TRAVEL_STEPS -> STOPPED same edge.
//  FALLING: DN_M==0 -> STOPPED, no step. Obstruct==1 -> STOPPED, no step, Obstr_Evt=1 next cycle.
//   Else prescaler as RISING, Position--; reaching 0 -> STOPPED same edge.
//  FAULT: motor halted, Position frozen. Exit to STOPPED when Fault_Clr & !(UP_M&DN_M).
//  Prescaler cleared on every state change; partial step progress is discarded.
//  Reversal (UP_M->DN_M directly): RISING->STOPPED at first edge, STOPPED->FALLING next edge;
//   minimum one-cycle dead time, never a direct RISING<->FALLING transition.
//  Latency: entry edge k into RISING/FALLING -> first step at edge k+STEP_DIV; full travel takes
//   TRAVEL_STEPS*STEP_DIV cycles after entry edge.
//  Position never wraps: saturates by construction at 0 and TRAVEL_STEPS.
//  Obstruct in STOPPED/RISING has no effect except blocking STOPPED->FALLING.
// STRUCTURE
//  garage_door_pkg: state encoding localparams (STOPPED=2'b00, RISING=2'b01, FALLING=2'b11,
//   FAULT=2'b10), shared with controller benches for state-name display.
//  Sub-module door_step_prescaler: counter 0..STEP_DIV-1 with clr/en inputs and step output;
//   top holds FSM, Position register, limit decode, Obstr_Evt register.
// TESTING (TRAVEL_STEPS=8, STEP_DIV=4, INIT_POS=0 unless stated)
//  1 Reset -> Position=0, DN_Max=1, UP_Max=0, Moving=0, Fault=0; DN_M=1 held -> stays STOPPED.
//  2 UP_M=1 held from edge k -> Position 1 at k+4 ... 8 at k+32; UP_Max=1, Moving=0 after k+32.
//  3 INIT_POS=8, DN_M=1; Obstruct=1 at Position 5 -> STOPPED, Position=5, one Obstr_Evt pulse.
//  4 UP_M=DN_M=1 while RISING at Position 3 -> Fault=1, Position=3 frozen; Fault_Clr=1 with
//    commands low -> STOPPED next edge, Fault=0.
//  5 UP_M released after 6 cycles -> Position=1, prescaler cleared; re-assert -> next step 4 cycles.
//  6 Closed loop with door controller, Activate pulse from closed -> open at 32 cycles, second
//    pulse -> closed; RST low mid-travel -> Position=INIT_POS, STOPPED next edge.

Source files
------------

// File: rtl/garage_door_pkg.sv
// Shared definitions for the garage door plant and the controller benches that display its state.
package garage_door_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'b00,
    RISING  = 2'b01,
    FAULT   = 2'b10,
    FALLING = 2'b11
  } door_state_e;

endpackage

// File: rtl/garage_door_plant_prescaler.sv
// Step prescaler: counts 0..STEP_DIV-1 while enabled and flags the cycle on which a position step is due.
module door_step_prescaler
  import garage_door_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    step = en && (cnt == LAST);
  end

endmodule

// File: rtl/garage_door_plant.sv
// Garage door plant: motor-command FSM, saturating position register, limit-switch decode
// and obstruction-abort event, driven by a step prescaler.
module garage_door_plant
  import garage_door_pkg::*;
#(
  parameter  int TRAVEL_STEPS = 8,
  parameter  int STEP_DIV     = 4,
  parameter  int INIT_POS     = 0,
  localparam int POS_W        = $clog2(TRAVEL_STEPS + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UP_M,
  input  logic             DN_M,
  input  logic             Obstruct,
  input  logic             Fault_Clr,
  output logic             UP_Max,
  output logic             DN_Max,
  output logic [POS_W-1:0] Position,
  output logic             Moving,
  output logic             Fault,
  output logic             Obstr_Evt
);

  localparam logic [POS_W-1:0] TOP_POS   = POS_W'(TRAVEL_STEPS);
  localparam logic [POS_W-1:0] RESET_POS = POS_W'(INIT_POS);

  door_state_e      state;
  door_state_e      state_next;
  logic [POS_W-1:0] pos_next;
  logic             evt_next;
  logic             both_cmd;
  logic             presc_en;
  logic             presc_clr;
  logic             step;

  always_comb begin
    both_cmd = UP_M & DN_M;
  end

  // Enable only when the current state will keep moving this edge; any state change clears progress.
  always_comb begin
    presc_en = !both_cmd &&
               ((state == RISING && UP_M) || (state == FALLING && DN_M && !Obstruct));
    presc_clr = (state_next != state);
  end

  door_step_prescaler #(
    .STEP_DIV(STEP_DIV)
  ) u_prescaler (
    .clk (CLK),
    .rst (RST),
    .clr (presc_clr),
    .en  (presc_en),
    .step(step)
  );

  always_comb begin
    state_next = state;
    pos_next   = Position;
    evt_next   = 1'b0;
    if (both_cmd) begin
      state_next = FAULT;
    end else begin
      unique case (state)
        STOPPED: begin
          if (UP_M && Position != TOP_POS) begin
            state_next = RISING;
          end else if (DN_M && Position != '0 && !Obstruct) begin
            state_next = FALLING;
          end
        end
        RISING: begin
          if (!UP_M) begin
            state_next = STOPPED;
          end else if (step) begin
            pos_next = Position + 1'b1;
            if (pos_next == TOP_POS) state_next = STOPPED;
          end
        end
        FALLING: begin
          if (!DN_M) begin
            state_next = STOPPED;
          end else if (Obstruct) begin
            state_next = STOPPED;
            evt_next   = 1'b1;
          end else if (step) begin
            pos_next = Position - 1'b1;
            if (pos_next == '0) state_next = STOPPED;
          end
        end
        FAULT: begin
          if (Fault_Clr) state_next = STOPPED;
        end
        default: state_next = STOPPED;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= STOPPED;
      Position  <= RESET_POS;
      Obstr_Evt <= 1'b0;
    end else begin
      state     <= state_next;
      Position  <= pos_next;
      Obstr_Evt <= evt_next;
    end
  end

  always_comb begin
    UP_Max = (Position == TOP_POS);
    DN_Max = (Position == '0);
    Moving = (state == RISING) || (state == FALLING);
    Fault  = (state == FAULT);
  end

endmodule

// File: tb/tb_garage_door_plant.sv
// Self-checking bench: two plants (closed and open at reset) share stimulus and are compared
// every cycle against a motion model based on elapsed time since motion started.
module tb_garage_door_plant;

  localparam int TS  = 8;
  localparam int DIV = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic UP_M = 1'b0;
  logic DN_M = 1'b0;
  logic Obstruct = 1'b0;
  logic Fault_Clr = 1'b0;

  logic       up_max [2];
  logic       dn_max [2];
  logic [3:0] position [2];
  logic       moving [2];
  logic       fault [2];
  logic       obstr_evt [2];

  garage_door_plant #(.TRAVEL_STEPS(TS), .STEP_DIV(DIV), .INIT_POS(0)) dut0 (
    .CLK(CLK), .RST(RST), .UP_M(UP_M), .DN_M(DN_M), .Obstruct(Obstruct), .Fault_Clr(Fault_Clr),
    .UP_Max(up_max[0]), .DN_Max(dn_max[0]), .Position(position[0]), .Moving(moving[0]),
    .Fault(fault[0]), .Obstr_Evt(obstr_evt[0]));

  garage_door_plant #(.TRAVEL_STEPS(TS), .STEP_DIV(DIV), .INIT_POS(8)) dut1 (
    .CLK(CLK), .RST(RST), .UP_M(UP_M), .DN_M(DN_M), .Obstruct(Obstruct), .Fault_Clr(Fault_Clr),
    .UP_Max(up_max[1]), .DN_Max(dn_max[1]), .Position(position[1]), .Moving(moving[1]),
    .Fault(fault[1]), .Obstr_Evt(obstr_evt[1]));

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;
  bit model_valid = 1'b0;

  // Model: mode 0 idle, 1 up, 2 down, 3 fault; position derived from start point plus elapsed cycles.
  int init_pos [2] = '{0, 8};
  int m_mode [2];
  int m_pos [2];
  int m_start [2];
  int m_elapsed [2];
  int m_evt [2];

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int evt;
      evt = 0;
      if (!RST) begin
        m_mode[i] = 0; m_pos[i] = init_pos[i];
      end else if (UP_M && DN_M) begin
        m_mode[i] = 3;
      end else begin
        case (m_mode[i])
          0: begin
            if (UP_M && m_pos[i] < TS) begin
              m_mode[i] = 1; m_start[i] = m_pos[i]; m_elapsed[i] = 0;
            end else if (DN_M && m_pos[i] > 0 && !Obstruct) begin
              m_mode[i] = 2; m_start[i] = m_pos[i]; m_elapsed[i] = 0;
            end
          end
          1: begin
            if (!UP_M) m_mode[i] = 0;
            else begin
              m_elapsed[i]++;
              m_pos[i] = m_start[i] + m_elapsed[i] / DIV;
              if (m_pos[i] == TS) m_mode[i] = 0;
            end
          end
          2: begin
            if (!DN_M) m_mode[i] = 0;
            else if (Obstruct) begin
              m_mode[i] = 0; evt = 1;
            end else begin
              m_elapsed[i]++;
              m_pos[i] = m_start[i] - m_elapsed[i] / DIV;
              if (m_pos[i] == 0) m_mode[i] = 0;
            end
          end
          default: if (Fault_Clr) m_mode[i] = 0;
        endcase
      end
      m_evt[i] = evt;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic [8:0] act, exp;
      act = {up_max[i], dn_max[i], moving[i], fault[i], obstr_evt[i], position[i]};
      exp = {m_pos[i] == TS, m_pos[i] == 0, m_mode[i] == 1 || m_mode[i] == 2, m_mode[i] == 3,
             m_evt[i] != 0, 4'(m_pos[i])};
      checks++;
      if (act === exp) passed++;
      else $display("FAIL dut%0d_outputs t=%0t got {upmax,dnmax,mov,flt,evt,pos}=%b expected %b",
                    i, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    model_valid = 1'b1;
    @(negedge CLK);
    if (model_valid) compare_all();
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    RST = 1'b0; UP_M = 1'b0; DN_M = 1'b0; Obstruct = 1'b0; Fault_Clr = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
  endtask

  initial begin
    @(negedge CLK);
    // 1: reset values, descend request at closed limit ignored
    do_reset();
    check_lit("rst_pos0", int'(position[0]), 0);
    check_lit("rst_dnmax0", int'(dn_max[0]), 1);
    check_lit("rst_upmax0", int'(up_max[0]), 0);
    check_lit("rst_moving0", int'(moving[0]), 0);
    check_lit("rst_fault0", int'(fault[0]), 0);
    check_lit("rst_pos1", int'(position[1]), 8);
    check_lit("rst_upmax1", int'(up_max[1]), 1);
    DN_M = 1'b1;
    repeat (3) tick();
    check_lit("dn_at_closed_moving", int'(moving[0]), 0);
    check_lit("dn_at_closed_pos", int'(position[0]), 0);

    // 2: full opening travel timing
    do_reset();
    UP_M = 1'b1;
    tick();
    check_lit("rise_entry_moving", int'(moving[0]), 1);
    check_lit("rise_entry_pos", int'(position[0]), 0);
    check_lit("up_at_open_moving", int'(moving[1]), 0);
    repeat (4) tick();
    check_lit("rise_first_step", int'(position[0]), 1);
    repeat (27) tick();
    check_lit("rise_k31_pos", int'(position[0]), 7);
    check_lit("rise_k31_moving", int'(moving[0]), 1);
    tick();
    check_lit("rise_k32_pos", int'(position[0]), 8);
    check_lit("rise_k32_upmax", int'(up_max[0]), 1);
    check_lit("rise_k32_moving", int'(moving[0]), 0);
    repeat (2) tick();
    UP_M = 1'b0;

    // 3: obstruction during descent from open
    do_reset();
    DN_M = 1'b1;
    repeat (13) tick();
    check_lit("fall_pos5", int'(position[1]), 5);
    Obstruct = 1'b1;
    tick();
    check_lit("obstr_pos", int'(position[1]), 5);
    check_lit("obstr_moving", int'(moving[1]), 0);
    check_lit("obstr_evt_hi", int'(obstr_evt[1]), 1);
    tick();
    check_lit("obstr_evt_lo", int'(obstr_evt[1]), 0);
    check_lit("obstr_blocks_fall", int'(moving[1]), 0);
    Obstruct = 1'b0; DN_M = 1'b0;
    tick();

    // 4: both commands -> fault, frozen position, clear rules
    do_reset();
    UP_M = 1'b1;
    repeat (13) tick();
    check_lit("fault_pre_pos", int'(position[0]), 3);
    DN_M = 1'b1;
    tick();
    check_lit("fault_set", int'(fault[0]), 1);
    check_lit("fault_set_dut1", int'(fault[1]), 1);
    repeat (5) tick();
    check_lit("fault_frozen", int'(position[0]), 3);
    Fault_Clr = 1'b1;
    tick();
    check_lit("fault_clr_blocked", int'(fault[0]), 1);
    UP_M = 1'b0; DN_M = 1'b0;
    tick();
    check_lit("fault_cleared", int'(fault[0]), 0);
    check_lit("fault_cleared_moving", int'(moving[0]), 0);
    Fault_Clr = 1'b0;
    tick();

    // 5: partial progress discarded on release
    do_reset();
    UP_M = 1'b1;
    repeat (6) tick();
    UP_M = 1'b0;
    repeat (2) tick();
    check_lit("release_pos", int'(position[0]), 1);
    UP_M = 1'b1;
    repeat (4) tick();
    check_lit("reassert_no_step", int'(position[0]), 1);
    tick();
    check_lit("reassert_step", int'(position[0]), 2);

    // reversal: one dead cycle in STOPPED
    UP_M = 1'b0; DN_M = 1'b1;
    tick();
    check_lit("reverse_dead", int'(moving[0]), 0);
    tick();
    check_lit("reverse_fall", int'(moving[0]), 1);
    repeat (DIV * 2 + 2) tick();
    check_lit("reverse_closed", int'(position[0]), 0);
    DN_M = 1'b0;

    // 6: reset mid-travel
    UP_M = 1'b1;
    repeat (10) tick();
    RST = 1'b0;
    tick();
    check_lit("midrst_pos0", int'(position[0]), 0);
    check_lit("midrst_moving0", int'(moving[0]), 0);
    check_lit("midrst_pos1", int'(position[1]), 8);
    RST = 1'b1; UP_M = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
